// File: rtl/sn74169_pkg.sv
// Shared types, phase lengths and the RCO helper for the SN74169 exerciser.
package sn74169_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StUp,
    StHold,
    StDown,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned UP_LEN    = 16;
  localparam int unsigned DOWN_LEN  = 16;
  localparam logic [5:0]  STEP_NONE = 6'h3F;

  // One expected-response entry travelling alongside the readback synchroniser.
  typedef struct packed {
    logic [3:0] q;
    logic       rcob;
    logic [5:0] step;
    logic       valid;
  } chk_t;

  // Active-low ripple carry: terminal count in the current direction while ENT is enabled.
  function automatic logic rco_b(input logic [3:0] q, input logic entb, input logic udb);
    return ~(~entb & (udb ? (q == 4'hF) : (q == 4'h0)));
  endfunction

endpackage

// File: rtl/sn74169_ref_model.sv
// Reference copy of the external counter: tracks the registered drive values edge for edge.
module sn74169_ref_model
  import sn74169_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] a_i,
  input  logic       loadb_i,
  input  logic       enpb_i,
  input  logic       entb_i,
  input  logic       udb_i,
  output logic [3:0] q_o,
  output logic       rcob_o
);

  logic [3:0] q_q, q_d;

  // Load wins over count; count wraps mod 16 in either direction.
  always_comb begin
    q_d = q_q;
    if (!loadb_i) begin
      q_d = a_i;
    end else if (!enpb_i && !entb_i) begin
      q_d = udb_i ? q_q + 4'd1 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign rcob_o = rco_b(q_q, entb_i, udb_i);

endmodule

// File: rtl/sn74169_exerciser.sv
// Drives a fixed load/up/hold/down sequence onto an external 4-bit up/down counter
// and checks the synchronised Q/RCOB readback against an internal reference model.
module sn74169_exerciser
  import sn74169_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] seed,
  output logic [3:0] a_out,
  output logic       enpb_out,
  output logic       entb_out,
  output logic       loadb_out,
  output logic       udb_out,
  input  logic [3:0] q_in,
  input  logic       rcob_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [5:0] first_err
);

  // Last step index of each phase; step runs continuously from LOAD through DRAIN.
  localparam logic [5:0] UpEnd    = 6'(UP_LEN);
  localparam logic [5:0] HoldEnd  = 6'(UP_LEN + HOLD_CYCLES);
  localparam logic [5:0] DownEnd  = 6'(UP_LEN + HOLD_CYCLES + DOWN_LEN);
  localparam logic [5:0] DrainEnd = 6'(UP_LEN + HOLD_CYCLES + DOWN_LEN + SYNC_STAGES + 1);

  state_e     state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [3:0] a_q, a_d;
  logic       enpb_q, enpb_d, entb_q, entb_d, loadb_q, loadb_d, udb_q, udb_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic [5:0] first_q, first_d;

  logic [SYNC_STAGES-1:0][3:0] qs_q;
  logic [SYNC_STAGES-1:0]      rs_q;
  chk_t [SYNC_STAGES-1:0]      dl_q;
  chk_t                        chk_d, head;
  logic [3:0]                  exp_q;
  logic                        exp_rcob, in_run, mismatch;

  sn74169_ref_model u_ref (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .a_i     (a_q),
    .loadb_i (loadb_q),
    .enpb_i  (enpb_q),
    .entb_i  (entb_q),
    .udb_i   (udb_q),
    .q_o     (exp_q),
    .rcob_o  (exp_rcob)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StUp;
      StUp:    if (step_q == UpEnd) state_d = StHold;
      StHold:  if (step_q == HoldEnd) state_d = StDown;
      StDown:  if (step_q == DownEnd) state_d = StDrain;
      StDrain: if (step_q == DrainEnd) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign step_d = (state_q == StIdle || state_q == StDone) ? 6'd0 : step_q + 6'd1;

  // Drive registers follow the next state so bus levels line up with state_q.
  always_comb begin
    a_d     = '0;
    enpb_d  = 1'b1;
    entb_d  = 1'b1;
    loadb_d = 1'b1;
    udb_d   = 1'b1;
    unique case (state_d)
      StLoad: begin
        loadb_d = 1'b0;
        a_d     = seed;
        enpb_d  = 1'b0;
        entb_d  = 1'b0;
      end
      StUp: begin
        enpb_d = 1'b0;
        entb_d = 1'b0;
      end
      StHold: entb_d = 1'b0;
      StDown: begin
        enpb_d = 1'b0;
        entb_d = 1'b0;
        udb_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_run = state_q inside {StLoad, StUp, StHold, StDown};
  assign chk_d  = '{q: exp_q, rcob: exp_rcob, step: step_q, valid: in_run};
  assign head   = dl_q[SYNC_STAGES-1];
  assign mismatch = head.valid &&
                    ((qs_q[SYNC_STAGES-1] != head.q) || (rs_q[SYNC_STAGES-1] != head.rcob));

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    if (state_q == StIdle && start) begin
      err_d   = '0;
      first_d = STEP_NONE;
      pass_d  = 1'b0;
    end else if (mismatch) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (first_q == STEP_NONE) first_d = head.step;
    end
    if (state_d == StDone) pass_d = (err_d == 8'd0);
  end

  assign busy_d = !(state_d inside {StIdle, StDone});
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      a_q     <= '0;
      enpb_q  <= 1'b1;
      entb_q  <= 1'b1;
      loadb_q <= 1'b1;
      udb_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= STEP_NONE;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      enpb_q  <= enpb_d;
      entb_q  <= entb_d;
      loadb_q <= loadb_d;
      udb_q   <= udb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Expectations ride a delay line as deep as the synchroniser so both reach the compare together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs_q <= '0;
      rs_q <= '0;
      dl_q <= '0;
    end else begin
      qs_q[0] <= q_in;
      rs_q[0] <= rcob_in;
      dl_q[0] <= chk_d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        qs_q[i] <= qs_q[i-1];
        rs_q[i] <= rs_q[i-1];
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign a_out     = a_q;
  assign enpb_out  = enpb_q;
  assign entb_out  = entb_q;
  assign loadb_out = loadb_q;
  assign udb_out   = udb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign first_err = first_q;

endmodule

// File: tb/tb_sn74169_exerciser.sv
// Loopback bench: behavioural counter with injectable readback faults, queue-based scoreboard.
module tb_sn74169_exerciser;

  localparam int S   = 2;
  localparam int H   = 4;
  localparam int LAT = 1 + 16 + H + 16 + S + 1;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic [5:0] first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seed = '0;
  logic [3:0] a_out, q_in;
  logic       enpb_out, entb_out, loadb_out, udb_out, rcob_in;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [5:0] first_err;

  logic [3:0] q_and = 4'hF;
  logic [3:0] q_or = 4'h0;
  logic       rf_en = 1'b0;
  logic       rf_val = 1'b1;
  logic [3:0] cnt_q;
  logic       cnt_rcob;
  logic [3:0] q0 = 4'h0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_rise_cyc = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sn74169_exerciser #(
    .SYNC_STAGES (S),
    .HOLD_CYCLES (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .a_out     (a_out),
    .enpb_out  (enpb_out),
    .entb_out  (entb_out),
    .loadb_out (loadb_out),
    .udb_out   (udb_out),
    .q_in      (q_in),
    .rcob_in   (rcob_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .first_err (first_err)
  );

  // Behavioural 74169 on the far side of the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'h0;
    else if (!loadb_out) cnt_q <= a_out;
    else if (!enpb_out && !entb_out) cnt_q <= udb_out ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  assign cnt_rcob = !(!entb_out && (udb_out ? (cnt_q == 4'hF) : (cnt_q == 4'h0)));
  assign q_in     = (cnt_q & q_and) | q_or;
  assign rcob_in  = rf_en ? rf_val : cnt_rcob;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walks the run step by step from the sequence's arithmetic and applies the readback fault.
  function automatic exp_t model(input logic [3:0] sd, input logic [3:0] qs, input logic [3:0] qa,
                                 input logic [3:0] qo, input logic rfe, input logic rfv);
    exp_t r;
    int q, nerr, first;
    bit up, er, orr;
    logic [3:0] oq;
    nerr  = 0;
    first = 63;
    for (int k = 0; k <= 32 + H; k++) begin
      if (k == 0) begin q = int'(qs); up = 1; end
      else if (k <= 16) begin q = (int'(sd) + k - 1) % 16; up = 1; end
      else if (k <= 16 + H) begin q = int'(sd); up = 1; end
      else begin q = (int'(sd) + 32 - (k - 17 - H)) % 16; up = 0; end
      er  = up ? (q != 15) : (q != 0);
      oq  = (4'(q) & qa) | qo;
      orr = rfe ? rfv : er;
      if (int'(oq) != q || orr != er) begin
        if (nerr < 255) nerr++;
        if (first == 63) first = k;
      end
    end
    r.pass  = (nerr == 0);
    r.err   = 8'(nerr);
    r.first = 6'(first);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      if (done) begin
        chk("done_width", int'(done_prev), 0);
        chk("busy_at_done", int'(busy), 0);
        chk("latency", cyc - busy_rise_cyc, LAT);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done with empty scoreboard (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pass", int'(pass), int'(mon_e.pass));
          chk("err_cnt", int'(err_cnt), int'(mon_e.err));
          chk("first_err", int'(first_err), int'(mon_e.first));
        end
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic wait_busy();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 8);
    if (!busy) chk("busy_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic launch(input logic [3:0] sd, input bit push, input exp_t e);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    if (push) sb_q.push_back(e);
    wait_busy();
    start = 1'b0;
  endtask

  task automatic set_fault(input logic [3:0] qa, input logic [3:0] qo, input logic rfe,
                           input logic rfv);
    q_and  = qa;
    q_or   = qo;
    rf_en  = rfe;
    rf_val = rfv;
  endtask

  task automatic run_lit(input logic [3:0] sd, input exp_t e);
    launch(sd, 1'b1, e);
    wait_done();
    q0 = sd;
  endtask

  task automatic run_model(input logic [3:0] sd);
    launch(sd, 1'b1, model(sd, q0, q_and, q_or, rf_en, rf_val));
    wait_done();
    q0 = sd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_out"}, int'(a_out), 0);
    chk({tag, "_enpb"}, int'(enpb_out), 1);
    chk({tag, "_entb"}, int'(entb_out), 1);
    chk({tag, "_loadb"}, int'(loadb_out), 1);
    chk({tag, "_udb"}, int'(udb_out), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_first_err"}, int'(first_err), 63);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, e2;
    logic [3:0] sd;
    int n, sel;
    #1 rst_n = 1'b0;
    #10 check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_lit(4'hA, '{pass: 1'b1, err: 8'd0, first: 6'h3F});
    run_lit(4'h0, '{pass: 1'b1, err: 8'd0, first: 6'h3F});
    set_fault(4'hE, 4'h0, 1'b0, 1'b1);
    run_lit(4'h0, '{pass: 1'b0, err: 8'd16, first: 6'd2});
    set_fault(4'hF, 4'h0, 1'b1, 1'b1);
    run_lit(4'hA, '{pass: 1'b0, err: 8'd2, first: 6'd6});
    set_fault(4'hF, 4'h0, 1'b0, 1'b1);

    // Abort a run in the middle of the up phase with an asynchronous reset.
    e = '0;
    launch(4'h5, 1'b0, e);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    q0 = 4'h0;
    run_lit(4'h3, '{pass: 1'b1, err: 8'd0, first: 6'h3F});

    // start held high: two runs separated by one idle cycle.
    sd = 4'($urandom_range(0, 15));
    e  = model(sd, q0, q_and, q_or, rf_en, rf_val);
    e2 = model(sd, sd, q_and, q_or, rf_en, rf_val);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    sb_q.push_back(e);
    sb_q.push_back(e2);
    wait_busy();
    wait_done();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 8);
    chk("b2b_gap", n, 2);
    start = 1'b0;
    wait_done();
    q0 = sd;

    for (int r = 0; r < 24; r++) begin
      sel = $urandom_range(0, 3);
      n   = $urandom_range(0, 3);
      unique case (sel)
        0: set_fault(4'hF, 4'h0, 1'b0, 1'b1);
        1: set_fault(~(4'b1 << n), 4'h0, 1'b0, 1'b1);
        2: set_fault(4'hF, 4'b1 << n, 1'b0, 1'b1);
        default: set_fault(4'hF, 4'h0, 1'b1, 1'($urandom_range(0, 1)));
      endcase
      run_model(4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
